// File: rtl/pattern_tx_1100_if.sv
// Bus bundle for pattern_tx_1100: transmission request inputs and the
// serial stream / status outputs. The clock and reset stay plain ports on the block.
interface pattern_tx_1100_if #(
  parameter int PAT_W = 4
);
  logic             start;
  logic             use_def;
  logic [PAT_W-1:0] pattern;
  logic [3:0]       reps;
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;

  // Requester side: issues start and pattern selection, observes the stream.
  modport master (
    output start, use_def, pattern, reps,
    input  x, valid, busy, done
  );

  // Transmitter side: consumes the request, produces the stream.
  modport slave (
    input  start, use_def, pattern, reps,
    output x, valid, busy, done
  );
endinterface

// File: rtl/pattern_tx_1100.sv
// pattern_tx_1100: serial pattern transmitter.
// Sends a PAT_W-bit pattern MSB first, repeated reps times, on registered x/valid.
// busy covers the transmission and done pulses for one cycle at the end.
// Optional feature macro: PATTERN_TX_GAP_EN inserts one idle GAP cycle
// between consecutive repetitions. It is disabled by default.
module pattern_tx_1100 #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = 4'b1100
) (
  input  logic            clk,
  input  logic            reset,   // asynchronous, active-low
  pattern_tx_1100_if.slave bus
);

  localparam int               CNT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PAT_W - 1);

`ifdef PATTERN_TX_GAP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;   // bits still to send in this repetition
  logic [PAT_W-1:0] pat_q,   pat_d;     // latched pattern, used for reloads
  logic [3:0]       reps_q,  reps_d;    // repetitions remaining, including the current one
  logic [CNT_W-1:0] bit_q,   bit_d;     // bits remaining in the current repetition minus one
  logic             x_q, valid_q, busy_q, done_q;
  logic             x_d, valid_d, busy_d, done_d;
  logic [PAT_W-1:0] sel_pat_s;

  // Next-state and datapath logic.
  // FIN accepts a start just like IDLE. A held start therefore restarts right after
  // the single FIN cycle, and busy is low there, so the inputs are live.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    reps_d    = reps_q;
    bit_d     = bit_q;
    sel_pat_s = bus.use_def ? DEF_PAT : bus.pattern;

    case (state_q)
      IDLE, FIN: begin
        if (bus.start) begin
          shreg_d = sel_pat_s;
          pat_d   = sel_pat_s;
          reps_d  = bus.reps;
          bit_d   = BIT_LAST;
          if (bus.reps != 4'd0) begin
            state_d = SHIFT;
          end else begin
            state_d = FIN;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (bit_q == {CNT_W{1'b0}}) begin
          // Last bit of this repetition: reload and count the repetition off.
          shreg_d = pat_q;
          bit_d   = BIT_LAST;
          reps_d  = reps_q - 4'd1;
          if (reps_q != 4'd1) begin
`ifdef PATTERN_TX_GAP_EN
            state_d = GAP;
`else
            state_d = SHIFT;
`endif
          end else begin
            state_d = FIN;
          end
        end else begin
          shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
          bit_d   = bit_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

`ifdef PATTERN_TX_GAP_EN
      GAP: begin
        state_d = SHIFT;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the outputs can be registered alongside it.
  always_comb begin
    valid_d = (state_d == SHIFT);
    x_d     = valid_d & shreg_d[PAT_W-1];
`ifdef PATTERN_TX_GAP_EN
    busy_d  = (state_d == SHIFT) || (state_d == GAP);
`else
    busy_d  = (state_d == SHIFT);
`endif
    done_d  = (state_d == FIN);
  end

  // State, datapath and output registers. Reset aborts any transmission immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= {PAT_W{1'b0}};
      pat_q   <= {PAT_W{1'b0}};
      reps_q  <= 4'd0;
      bit_q   <= {CNT_W{1'b0}};
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pat_q   <= pat_d;
      reps_q  <= reps_d;
      bit_q   <= bit_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x     = x_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
